// File: rtl/vector_sequencer_pkg.sv
// Shared definitions for the vector display-list player: FSM states and
// point-word field positions, layout {jump, color, x, y} MSB first.
package vector_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_PARK,
    S_HOLD,
    S_DONE
  } state_t;

  localparam int Y_LSB = 0;

  function automatic int x_lsb(input int coord_w);
    return coord_w;
  endfunction

  function automatic int color_lsb(input int coord_w);
    return 2 * coord_w;
  endfunction

  function automatic int jump_bit(input int coord_w, input int ch, input int cw);
    return 2 * coord_w + ch * cw;
  endfunction

  function automatic int point_w(input int coord_w, input int ch, input int cw);
    return 1 + ch * cw + 2 * coord_w;
  endfunction

endpackage

// File: rtl/vector_sequencer_frame_timer.sv
// Saturating frame-period counter. o_at_limit is raised one cycle early so
// that the DONE state lands exactly MIN_FRAME_CYC cycles after frame start.
module frame_timer #(
  parameter int MIN_FRAME_CYC = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_run,
  output logic o_at_limit
);

  localparam int W   = (MIN_FRAME_CYC > 0) ? $clog2(MIN_FRAME_CYC + 1) : 1;
  localparam int TGT = (MIN_FRAME_CYC > 0) ? MIN_FRAME_CYC - 1 : 0;
  localparam logic [W-1:0] TARGET = W'(TGT);
  localparam logic [W-1:0] FIRST  = (TGT > 0) ? W'(1) : '0;

  logic [W-1:0] r_cnt;

  // The start edge itself is the first counted cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= FIRST;
    end else if (i_run && r_cnt != TARGET) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_at_limit = (r_cnt == TARGET);

endmodule

// File: rtl/vector_sequencer.sv
// Display-list player: walks point memory once per frame, emits draw/jump
// commands on a valid/ready link, parks the beam and pulses frame_done.
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int COORD_W       = 12,
  parameter int CH            = 1,
  parameter int CW            = 1,
  parameter int AW            = 11,
  parameter int RD_LAT        = 1,
  parameter int PARK_X        = 2048,
  parameter int PARK_Y        = 2048,
  parameter int MIN_FRAME_CYC = 0,
  localparam int POINT_W      = point_w(COORD_W, CH, CW)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_ready,
  input  logic [AW-1:0]      num_points,
  output logic [AW-1:0]      rd_addr,
  input  logic [POINT_W-1:0] rd_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_jump,
  output logic [CH*CW-1:0]   cmd_color,
  output logic [COORD_W-1:0] cmd_x,
  output logic [COORD_W-1:0] cmd_y,
  output logic               frame_done,
  output logic               busy
);

  localparam int JUMP_BIT  = jump_bit(COORD_W, CH, CW);
  localparam int COLOR_LSB = color_lsb(COORD_W);
  localparam int X_LSB     = x_lsb(COORD_W);

  state_t             r_state;
  logic [AW-1:0]      r_cnt;
  logic [AW-1:0]      r_idx;
  logic [AW-1:0]      r_rd_addr;
  logic [1:0]         r_wait;
  logic               r_valid;
  logic               r_jump;
  logic [CH*CW-1:0]   r_color;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_done;
  logic               r_busy;

  logic               w_start;
  logic               w_at_limit;
  logic               w_jump;
  logic [CH*CW-1:0]   w_color;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;

  assign w_start = (r_state == S_IDLE) && enable && frame_ready;
  assign w_jump  = rd_data[JUMP_BIT];
  assign w_color = rd_data[COLOR_LSB +: CH*CW];
  assign w_x     = rd_data[X_LSB +: COORD_W];
  assign w_y     = rd_data[Y_LSB +: COORD_W];

  frame_timer #(.MIN_FRAME_CYC(MIN_FRAME_CYC)) u_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (w_start),
    .i_run      (r_state != S_IDLE),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_wait    <= '0;
      r_valid   <= 1'b0;
      r_jump    <= 1'b0;
      r_color   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt     <= num_points;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_wait    <= '0;
            r_busy    <= 1'b1;
            if (num_points != '0) begin
              r_state <= S_FETCH;
            end else begin
              r_state <= S_PARK;
              r_valid <= 1'b1;
              r_jump  <= 1'b1;
              r_color <= '0;
              r_x     <= COORD_W'(PARK_X);
              r_y     <= COORD_W'(PARK_Y);
            end
          end
        end
        // rd_addr became visible on entry, so data arrives RD_LAT cycles later.
        S_FETCH: begin
          if (r_wait == 2'(RD_LAT)) begin
            r_wait  <= '0;
            r_jump  <= w_jump;
            r_color <= w_jump ? '0 : w_color;
            r_x     <= w_x;
            r_y     <= w_y;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        // Compare before incrementing so a full-depth count cannot wrap idx.
        S_ISSUE: begin
          if (cmd_ready) begin
            if (r_idx == r_cnt - AW'(1)) begin
              r_state <= S_PARK;
              r_jump  <= 1'b1;
              r_color <= '0;
              r_x     <= COORD_W'(PARK_X);
              r_y     <= COORD_W'(PARK_Y);
            end else begin
              r_idx     <= r_idx + AW'(1);
              r_rd_addr <= r_idx + AW'(1);
              r_valid   <= 1'b0;
              r_state   <= S_FETCH;
            end
          end
        end
        S_PARK: begin
          if (cmd_ready) begin
            r_valid <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_at_limit) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_addr    = r_rd_addr;
  assign cmd_valid  = r_valid;
  assign cmd_jump   = r_jump;
  assign cmd_color  = r_color;
  assign cmd_x      = r_x;
  assign cmd_y      = r_y;
  assign frame_done = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench: DUT A uses default parameters (mono, RD_LAT 1, no frame
// limit); DUT B is RGB 3x4 bits, RD_LAT 2, MIN_FRAME_CYC 100.
module tb_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        a_reset, a_enable, a_frame_ready, a_cmd_ready;
  logic [10:0] a_num_points, a_rd_addr;
  logic [25:0] a_rd_data;
  logic        a_cmd_valid, a_cmd_jump, a_frame_done, a_busy;
  logic [0:0]  a_cmd_color;
  logic [11:0] a_cmd_x, a_cmd_y;

  logic        b_reset, b_enable, b_frame_ready, b_cmd_ready;
  logic [10:0] b_num_points, b_rd_addr;
  logic [36:0] b_rd_data;
  logic        b_cmd_valid, b_cmd_jump, b_frame_done, b_busy;
  logic [11:0] b_cmd_color;
  logic [11:0] b_cmd_x, b_cmd_y;

  vector_sequencer dut_a (
    .clk(clk), .reset(a_reset), .enable(a_enable), .frame_ready(a_frame_ready),
    .num_points(a_num_points), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_jump(a_cmd_jump),
    .cmd_color(a_cmd_color), .cmd_x(a_cmd_x), .cmd_y(a_cmd_y),
    .frame_done(a_frame_done), .busy(a_busy)
  );

  vector_sequencer #(
    .COORD_W(12), .CH(3), .CW(4), .AW(11), .RD_LAT(2),
    .PARK_X(2048), .PARK_Y(2048), .MIN_FRAME_CYC(100)
  ) dut_b (
    .clk(clk), .reset(b_reset), .enable(b_enable), .frame_ready(b_frame_ready),
    .num_points(b_num_points), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_jump(b_cmd_jump),
    .cmd_color(b_cmd_color), .cmd_x(b_cmd_x), .cmd_y(b_cmd_y),
    .frame_done(b_frame_done), .busy(b_busy)
  );

  // Point memories with exact read latency.
  logic [25:0] mem_a [0:2047];
  logic [36:0] mem_b [0:2047];
  logic [25:0] a_pipe;
  logic [36:0] b_pipe0, b_pipe1;

  always_ff @(posedge clk) begin
    a_pipe  <= mem_a[a_rd_addr];
    b_pipe0 <= mem_b[b_rd_addr];
    b_pipe1 <= b_pipe0;
  end
  assign a_rd_data = a_pipe;
  assign b_rd_data = b_pipe1;

  logic [63:0] w_cmd_a, w_cmd_b;
  assign w_cmd_a = 64'({a_cmd_jump, a_cmd_color, a_cmd_x, a_cmd_y});
  assign w_cmd_b = 64'({b_cmd_jump, b_cmd_color, b_cmd_x, b_cmd_y});

  typedef struct {
    int npts;
    int exp_done;
  } frame_vec_t;

  frame_vec_t  tab [4];
  logic [63:0] exp_a [4];
  logic [63:0] exp_b [3];
  logic [63:0] park_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_a(input int npts);
    a_num_points  = 11'(npts);
    a_frame_ready = 1'b1;
    a_enable      = 1'b1;
    @(posedge clk);
    #1;
    a_frame_ready = 1'b0;
    a_enable      = 1'b0;
  endtask

  task automatic wait_valid_a(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (a_cmd_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  // One frame on DUT A with cmd_ready high; cycle k = k-th cycle after start.
  task automatic run_frame_a(input int npts, input int exp_done);
    int ncmd, ndone, done_cyc;
    ncmd = 0;
    ndone = 0;
    done_cyc = -1;
    start_a(npts);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk($sformatf("rd_addr_start_n%0d", npts), 64'(a_rd_addr), 64'd0);
      if (a_cmd_valid) begin
        if (ncmd <= npts)
          chk($sformatf("cmd%0d_n%0d", ncmd, npts), w_cmd_a, (ncmd < npts) ? exp_a[ncmd] : park_a);
        ncmd++;
      end
      if (a_frame_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
    chk($sformatf("cmd_count_n%0d", npts), 64'(ncmd), 64'(npts + 1));
    chk($sformatf("done_count_n%0d", npts), 64'(ndone), 64'd1);
    chk($sformatf("done_cycle_n%0d", npts), 64'(done_cyc), 64'(exp_done));
    chk($sformatf("idle_after_n%0d", npts), 64'(a_busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    int n, nd, first_b;
    int bdone [2];

    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = {1'b0, 1'b1, 12'd100, 12'd200};
    mem_a[1] = {1'b0, 1'b1, 12'd300, 12'd200};
    mem_a[2] = {1'b1, 1'b0, 12'd0,   12'd0};
    mem_a[3] = {1'b1, 1'b1, 12'd500, 12'd600};
    mem_b[0] = {1'b0, 12'hABC, 12'd10, 12'd20};
    mem_b[1] = {1'b1, 12'hFFF, 12'd30, 12'd40};

    exp_a[0] = 64'({1'b0, 1'b1, 12'd100, 12'd200});
    exp_a[1] = 64'({1'b0, 1'b1, 12'd300, 12'd200});
    exp_a[2] = 64'({1'b1, 1'b0, 12'd0,   12'd0});
    exp_a[3] = 64'({1'b1, 1'b0, 12'd500, 12'd600});
    park_a   = 64'({1'b1, 1'b0, 12'd2048, 12'd2048});
    exp_b[0] = 64'({1'b0, 12'hABC, 12'd10,   12'd20});
    exp_b[1] = 64'({1'b1, 12'h000, 12'd30,   12'd40});
    exp_b[2] = 64'({1'b1, 12'h000, 12'd2048, 12'd2048});

    // 3 cycles per point at RD_LAT 1, plus PARK, HOLD and DONE.
    tab[0] = '{npts: 3, exp_done: 12};
    tab[1] = '{npts: 0, exp_done: 3};
    tab[2] = '{npts: 4, exp_done: 15};
    tab[3] = '{npts: 1, exp_done: 6};

    a_reset = 1'b1; a_enable = 1'b0; a_frame_ready = 1'b0; a_cmd_ready = 1'b1; a_num_points = '0;
    b_reset = 1'b1; b_enable = 1'b0; b_frame_ready = 1'b0; b_cmd_ready = 1'b1; b_num_points = 11'd2;
    @(negedge clk);
    @(negedge clk);
    chk("reset_a", 64'({a_rd_addr, a_cmd_valid, a_cmd_jump, a_cmd_color, a_cmd_x, a_cmd_y, a_frame_done, a_busy}), 64'd0);
    chk("reset_b", 64'({b_rd_addr, b_cmd_valid, b_cmd_jump, b_cmd_color, b_cmd_x, b_cmd_y, b_frame_done, b_busy}), 64'd0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_frame_a(tab[i].npts, tab[i].exp_done);

    // Back-pressure on point 1 for 5 cycles.
    a_cmd_ready = 1'b0;
    start_a(3);
    wait_valid_a("stall_pt0_valid");
    a_cmd_ready = 1'b1;
    @(negedge clk);
    a_cmd_ready = 1'b0;
    wait_valid_a("stall_pt1_valid");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_hold%0d", i), 64'({a_cmd_valid, a_rd_addr, w_cmd_a[25:0]}),
          64'({1'b1, 11'd1, exp_a[1][25:0]}));
      @(negedge clk);
    end
    a_cmd_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_cmd_valid) begin
        if (n < 3) chk($sformatf("stall_after%0d", n), w_cmd_a, (n == 0) ? exp_a[1] : (n == 1) ? exp_a[2] : park_a);
        n++;
      end
      @(negedge clk);
    end
    chk("stall_cmd_count", 64'(n), 64'd3);

    // Reset while a point command is waiting in ISSUE.
    a_cmd_ready = 1'b0;
    start_a(3);
    wait_valid_a("abort_valid");
    a_reset = 1'b1;
    #1;
    chk("abort_now", 64'({a_cmd_valid, a_busy, a_frame_done}), 64'd0);
    @(negedge clk);
    chk("abort_next", 64'({a_cmd_valid, a_busy, a_frame_done, a_rd_addr}), 64'd0);
    a_reset = 1'b0;
    a_cmd_ready = 1'b1;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (a_frame_done || a_busy) nd++;
    end
    chk("abort_quiet", 64'(nd), 64'd0);
    run_frame_a(3, 12);

    // DUT B: continuous frames, 4 cycles per point, frame period of 100.
    n = 0;
    nd = 0;
    first_b = -1;
    bdone[0] = -1;
    bdone[1] = -1;
    b_frame_ready = 1'b1;
    b_enable = 1'b1;
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      if (b_cmd_valid) begin
        if (first_b < 0) first_b = k;
        if (n < 6) chk($sformatf("b_cmd%0d", n), w_cmd_b, exp_b[n % 3]);
        n++;
      end
      if (b_frame_done) begin
        if (nd < 2) bdone[nd] = k;
        nd++;
      end
      if (k == 101) chk("b_idle_gap", 64'(b_busy), 64'd0);
      if (k == 102) chk("b_restart", 64'(b_busy), 64'd1);
      if (k == 201) b_enable = 1'b0;
      if (k == 205) chk("b_stopped", 64'(b_busy), 64'd0);
    end
    chk("b_first_issue", 64'(first_b), 64'd4);
    chk("b_cmd_count", 64'(n), 64'd6);
    chk("b_done_count", 64'(nd), 64'd2);
    chk("b_done1_cycle", 64'(bdone[0]), 64'd100);
    chk("b_done2_cycle", 64'(bdone[1]), 64'd201);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
